cmp_issue_ctrl: RTL and testbench

//  Initiator for CMP_UNIT: accepts compare commands over valid/ready and drives the comparator operands, ALU_FUN and CMP_Enable.

---
 rtl/cmp_issue_pkg.sv | 21 ++
 rtl/cmp_rsp_decode.sv | 22 ++
 rtl/cmp_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_cmp_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_issue_pkg.sv
// Shared encodings for the comparator issue controller: FSM states, ALU_FUN codes and result codes.
package cmp_issue_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] FUN_NOP = 2'b00;
  localparam logic [1:0] FUN_EQ  = 2'b01;
  localparam logic [1:0] FUN_GT  = 2'b10;
  localparam logic [1:0] FUN_LT  = 2'b11;

  localparam int CODE_NONE = 0;
  localparam int CODE_EQ   = 1;
  localparam int CODE_GT   = 2;
  localparam int CODE_LT   = 3;

endpackage

// File: rtl/cmp_rsp_decode.sv
// Combinational decode of a comparator result code against the function that was issued.
module cmp_rsp_decode
  import cmp_issue_pkg::*;
#(
  parameter int CMP_OUT_WIDTH = 16
) (
  input  logic [CMP_OUT_WIDTH-1:0] code,
  input  logic [1:0]               fun,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt,
  output logic                     err
);

  assign eq = (code == CMP_OUT_WIDTH'(CODE_EQ));
  assign gt = (code == CMP_OUT_WIDTH'(CODE_GT));
  assign lt = (code == CMP_OUT_WIDTH'(CODE_LT));

  // A function's only legal non-zero result is its own code, so NOP only ever allows 0.
  assign err = (code != CMP_OUT_WIDTH'(CODE_NONE)) && (code != CMP_OUT_WIDTH'(fun));

endmodule

// File: rtl/cmp_issue_ctrl.sv
// Issues one compare command at a time to CMP_UNIT and returns the decoded result with timeout detection.
// Optional saturating response statistics are built when CMP_ISSUE_STATS_EN is defined.
module cmp_issue_ctrl
  import cmp_issue_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 16,
  parameter int CMP_OUT_WIDTH = 16,
  parameter int TIMEOUT_CYC   = 4
`ifdef CMP_ISSUE_STATS_EN
  ,
  parameter int STAT_WIDTH    = 16
`endif
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [IN_DATA_WIDTH-1:0] cmd_a,
  input  logic [IN_DATA_WIDTH-1:0] cmd_b,
  input  logic [1:0]               cmd_fun,
  output logic [IN_DATA_WIDTH-1:0] A,
  output logic [IN_DATA_WIDTH-1:0] B,
  output logic [1:0]               ALU_FUN,
  output logic                     CMP_Enable,
  input  logic [CMP_OUT_WIDTH-1:0] CMP_OUT,
  input  logic                     CMP_Flag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CMP_OUT_WIDTH-1:0] rsp_code,
  output logic                     rsp_eq,
  output logic                     rsp_gt,
  output logic                     rsp_lt,
  output logic                     rsp_err
`ifdef CMP_ISSUE_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [STAT_WIDTH-1:0]    cnt_eq,
  output logic [STAT_WIDTH-1:0]    cnt_gt,
  output logic [STAT_WIDTH-1:0]    cnt_lt,
  output logic [STAT_WIDTH-1:0]    cnt_err
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          dec_eq, dec_gt, dec_lt, dec_err;

  cmp_rsp_decode #(.CMP_OUT_WIDTH(CMP_OUT_WIDTH)) u_decode (
    .code (CMP_OUT),
    .fun  (ALU_FUN),
    .eq   (dec_eq),
    .gt   (dec_gt),
    .lt   (dec_lt),
    .err  (dec_err)
  );

  // CMP_Enable is raised on the accept edge so it is high for exactly the ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      CMP_Enable <= 1'b0;
      A          <= '0;
      B          <= '0;
      ALU_FUN    <= FUN_NOP;
      rsp_valid  <= 1'b0;
      rsp_code   <= '0;
      rsp_eq     <= 1'b0;
      rsp_gt     <= 1'b0;
      rsp_lt     <= 1'b0;
      rsp_err    <= 1'b0;
      timer      <= '0;
    end else begin
      CMP_Enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            A          <= cmd_a;
            B          <= cmd_b;
            ALU_FUN    <= cmd_fun;
            cmd_ready  <= 1'b0;
            CMP_Enable <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (CMP_Flag) begin
            rsp_code  <= CMP_OUT;
            rsp_eq    <= dec_eq;
            rsp_gt    <= dec_gt;
            rsp_lt    <= dec_lt;
            rsp_err   <= dec_err;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT_CYC)) begin
            rsp_code  <= '0;
            rsp_eq    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CMP_ISSUE_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counters advance only when a response is actually consumed; clearing wins over counting.
  always_ff @(posedge CLK) begin
    if (rst || stats_clr) begin
      cnt_eq  <= '0;
      cnt_gt  <= '0;
      cnt_lt  <= '0;
      cnt_err <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_eq)  cnt_eq  <= sat_inc(cnt_eq);
      if (rsp_gt)  cnt_gt  <= sat_inc(cnt_gt);
      if (rsp_lt)  cnt_lt  <= sat_inc(cnt_lt);
      if (rsp_err) cnt_err <= sat_inc(cnt_err);
    end
  end
`endif

endmodule

// File: tb/tb_cmp_issue_ctrl.sv
// Scoreboard bench for cmp_issue_ctrl with a comparator stub; stats checks build with CMP_ISSUE_STATS_EN.
module tb_cmp_issue_ctrl;
  import cmp_issue_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [1:0]    cmd_fun = 2'b00;
  logic [DW-1:0] A, B;
  logic [1:0]    ALU_FUN;
  logic          CMP_Enable;
  logic [CW-1:0] CMP_OUT = '0;
  logic          CMP_Flag = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] rsp_code;
  logic          rsp_eq, rsp_gt, rsp_lt, rsp_err;
`ifdef CMP_ISSUE_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   cnt_eq, cnt_gt, cnt_lt, cnt_err;
`endif

  typedef struct {
    logic [CW-1:0] code;
    logic [3:0]    flags;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // 0: answers like a comparator, 1: never answers, 2: answers with stub_code
  int            stub_mode = 0;
  logic [CW-1:0] stub_code = '0;
  logic          en_d = 1'b0;

  always #5 CLK = ~CLK;

  cmp_issue_ctrl #(.IN_DATA_WIDTH(DW), .CMP_OUT_WIDTH(CW), .TIMEOUT_CYC(TO)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_fun    (cmd_fun),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .CMP_Enable (CMP_Enable),
    .CMP_OUT    (CMP_OUT),
    .CMP_Flag   (CMP_Flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_code   (rsp_code),
    .rsp_eq     (rsp_eq),
    .rsp_gt     (rsp_gt),
    .rsp_lt     (rsp_lt),
    .rsp_err    (rsp_err)
`ifdef CMP_ISSUE_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .cnt_eq     (cnt_eq),
    .cnt_gt     (cnt_gt),
    .cnt_lt     (cnt_lt),
    .cnt_err    (cnt_err)
`endif
  );

  function automatic logic [CW-1:0] stub_result(input logic [1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f)
      FUN_EQ:  return (a == b) ? 16'd1 : 16'd0;
      FUN_GT:  return (a > b)  ? 16'd2 : 16'd0;
      FUN_LT:  return (a < b)  ? 16'd3 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  // Comparator stub: answers two edges after it sees CMP_Enable, as a registered CMP_UNIT would.
  always @(posedge CLK) begin
    if (rst) begin
      en_d     <= 1'b0;
      CMP_Flag <= 1'b0;
    end else begin
      en_d     <= CMP_Enable;
      CMP_Flag <= 1'b0;
      if (en_d && stub_mode != 1) begin
        CMP_Flag <= 1'b1;
        CMP_OUT  <= (stub_mode == 2) ? stub_code : stub_result(ALU_FUN, A, B);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every consumed response is compared with the oldest expected entry.
  always @(negedge CLK) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rsp_code", 64'(rsp_code), 64'(mon_e.code));
        checkOutput("rsp_flags", 64'({rsp_eq, rsp_gt, rsp_lt, rsp_err}), 64'(mon_e.flags));
      end
    end
  end

  // Issues one command, checks operand registering, the enable pulse and latency, then consumes the response.
  task automatic applyStimulus(input string name, input logic [1:0] fun, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input int mode, input logic [CW-1:0] forced,
                               input logic [CW-1:0] e_code, input logic [3:0] e_flags, input int e_lat);
    int n;
    int lat;
    int en_cnt;
    exp_t e;
    stub_mode = mode;
    stub_code = forced;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_fun   = fun;
    e.code    = e_code;
    e.flags   = e_flags;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    checkOutput({name, "_operands"}, 64'({A, B, ALU_FUN}), 64'({a, b, fun}));
    en_cnt = int'(CMP_Enable);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
      en_cnt += int'(CMP_Enable);
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(e_lat));
    checkOutput({name, "_enable_pulses"}, 64'(en_cnt), 64'd1);
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    checkOutput({name, "_release"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  initial begin
    int n;
    int bad;
    exp_t e;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_ctrl", 64'({cmd_ready, CMP_Enable, rsp_valid}), 64'(3'b100));
    checkOutput("reset_operands", 64'({A, B, ALU_FUN}), 64'd0);
    checkOutput("reset_rsp", 64'({rsp_code, rsp_eq, rsp_gt, rsp_lt, rsp_err}), 64'd0);
    rst = 1'b0;
    @(posedge CLK); #1;

    // Reset while waiting on a silent comparator must abort without a response.
    stub_mode = 1;
    cmd_valid = 1'b1; cmd_a = 16'h00AA; cmd_b = 16'h00AA; cmd_fun = FUN_EQ;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst = 1'b1;
    @(posedge CLK); #1;
    checkOutput("abort_ctrl", 64'({cmd_ready, CMP_Enable, rsp_valid}), 64'(3'b100));
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (rsp_valid) bad++;
    end
    checkOutput("abort_no_rsp", 64'(bad), 64'd0);

    applyStimulus("eq_match", FUN_EQ, 16'h1234, 16'h1234, 0, 16'd0, 16'd1, 4'b1000, 3);
    applyStimulus("gt",       FUN_GT, 16'd5,    16'd3,    0, 16'd0, 16'd2, 4'b0100, 3);
    applyStimulus("lt",       FUN_LT, 16'd3,    16'd5,    0, 16'd0, 16'd3, 4'b0010, 3);
    applyStimulus("nop",      FUN_NOP, 16'd9,   16'd9,    0, 16'd0, 16'd0, 4'b0000, 3);
    applyStimulus("eq_miss",  FUN_EQ, 16'd1,    16'd2,    0, 16'd0, 16'd0, 4'b0000, 3);
    applyStimulus("timeout",  FUN_GT, 16'd7,    16'd1,    1, 16'd0, 16'd0, 4'b0001, TO + 2);
    applyStimulus("inconsistent", FUN_EQ, 16'd1, 16'd1,   2, 16'd3, 16'd3, 4'b0011, 3);

    // Back-pressure: response held for 10 cycles while the next command waits.
    stub_mode = 0;
    cmd_valid = 1'b1; cmd_a = 16'd7; cmd_b = 16'd7; cmd_fun = FUN_EQ;
    e.code = 16'd1; e.flags = 4'b1000;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    cmd_a = 16'd9; cmd_b = 16'd9;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("hold_latency", 64'(n), 64'd3);
    bad = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (!(rsp_valid && rsp_code == 16'd1 && rsp_eq && !rsp_err && !cmd_ready)) bad++;
    end
    checkOutput("hold_stable", 64'(bad), 64'd0);
    exp_q.push_back(e);
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    checkOutput("hold_idle_after", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    checkOutput("hold_next_accept", 64'({cmd_ready, A}), 64'({1'b0, 16'd9}));
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("next_latency", 64'(n), 64'd3);
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

`ifdef CMP_ISSUE_STATS_EN
    checkOutput("cnt_eq",  64'(cnt_eq),  64'd3);
    checkOutput("cnt_gt",  64'(cnt_gt),  64'd1);
    checkOutput("cnt_lt",  64'(cnt_lt),  64'd2);
    checkOutput("cnt_err", 64'(cnt_err), 64'd2);
    stats_clr = 1'b1;
    @(posedge CLK); #1;
    stats_clr = 1'b0;
    checkOutput("cnt_clear", 64'({cnt_eq, cnt_gt, cnt_lt, cnt_err}), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
